pc_sequencer: RTL and testbench
===============================

PC_SEQUENCER -- requirements
Module: pc_sequencer

Interface
REQ-001 Parameters SHALL be:
- D, default 12: program-counter width.
- LW, default 6: target-table index width; the table has 2**LW entries.
- SD, default 4: return-stack depth.
- DONE_ADDR, default 128, D bits: halt address.
REQ-002 Ports SHALL be as listed below. There is one clock. Reset is asynchronous and active-low.
- clk  in  1  clock
- reset  in  1  asynchronous, active-low reset
- req  in  1  run request
- stall  in  1  hold PC
- jump_en, branch_en, call_en, ret_en  in  1 each  flow-control strobes
- flag_sel  in  2  branch condition: 00 zero, 01 !zero, 10 pari, 11 sc
- zero, pari, sc  in  1 each  registered ALU flags
- lut_idx  in  LW  target-table read index
- lut_we  in  1  target-table write enable
- lut_wr_idx  in  LW  target-table write index
- lut_wr_addr  in  D  target-table write data
- prog_ctr  out  D  current fetch address
- fetch_valid  out  1  prog_ctr is a live fetch this cycle
- busy  out  1  state is RUN
- done  out  1  state is DONE
- stack_err  out  1  sticky return-stack overflow/underflow

Function
REQ-003 The FSM SHALL have states IDLE, RUN, DONE.
- IDLE->RUN when req=1.
- RUN->DONE when prog_ctr==DONE_ADDR; stall does not block this.
- DONE->IDLE when req=0.
REQ-004 prog_ctr SHALL be 0 in IDLE and SHALL be 0 in the first RUN cycle.
REQ-005 On entry to IDLE, prog_ctr SHALL be forced to 0 and the return stack emptied.
REQ-006 fetch_valid SHALL be 1 only when state is RUN, stall=0 and prog_ctr!=DONE_ADDR.
REQ-007 In RUN with stall=0, next PC SHALL be chosen by priority (highest first):
- ret_en: pop
- call_en: push prog_ctr+1, then go to lut[lut_idx]
- jump_en: lut[lut_idx]
- branch_en with selected flag=1: lut[lut_idx]
- otherwise: prog_ctr+1
REQ-008 In RUN with stall=1, prog_ctr and the stack SHALL hold, and all strobes SHALL be ignored.
REQ-009 All strobes, stall and lut reads SHALL be ignored in IDLE and DONE; lut writes SHALL still be accepted.
REQ-010 prog_ctr+1 SHALL wrap modulo 2**D.
REQ-011 The target table SHALL have 2**LW entries of D bits.
- Synchronous write when lut_we=1.
- Combinational read.
- Writing and reading the same index in the same cycle returns the old value.
REQ-012 A call with the stack holding SD entries SHALL:
- set stack_err;
- skip the push;
- still load lut[lut_idx].
REQ-013 A ret with an empty stack SHALL set stack_err and advance to prog_ctr+1.
REQ-014 stack_err SHALL stay set until reset or the IDLE->RUN transition.
REQ-015 The next-PC decision SHALL be single-cycle: a strobe sampled at edge n determines prog_ctr after edge n.

Reset
REQ-016 Asserting reset (low) SHALL asynchronously force the following, including mid-run:
- state IDLE
- prog_ctr 0
- busy, done, fetch_valid, stack_err 0
- stack empty
- all target-table entries 0
REQ-017 Deassertion of reset SHALL take effect on the next rising clk edge; req is not sampled before that edge.

Structure
REQ-018 Package pc_seq_pkg SHALL hold:
- the state enum (IDLE, RUN, DONE);
- the flag_sel encoding constants;
- the next-PC source enum (RET, CALL, JUMP, BRANCH, SEQ).
REQ-019 The return stack SHALL be a sub-module, ret_stack, parametrised by SD and D, with push, pop, full, empty and top.
REQ-020 The target table and FSM SHALL reside in pc_sequencer.

Verification (defaults unless stated)
REQ-021 Run to done:
- Stimulus: reset released, req=1, no strobes.
- Response: busy=1; prog_ctr 0,1,...,128; done=1 the cycle after prog_ctr==128; fetch_valid=0 at 128.
- Then req=0: done=0 and prog_ctr=0 next cycle.
REQ-022 Jump:
- Stimulus: write lut[5]=40; at prog_ctr=10 assert jump_en with lut_idx=5.
- Response: next prog_ctr=40.
- Also: write and read lut[5] in the same cycle returns the old value.
REQ-023 Branch:
- Stimulus: flag_sel=00, branch_en=1, lut[2]=60, at prog_ctr=7.
- Response: zero=0 gives 8; zero=1 gives 60.
- Also: flag_sel=11 with sc=1 is taken.
- Also: jump_en and branch_en together follow the jump.
REQ-024 Call/return:
- Stimulus: lut[1]=20; call at prog_ctr=3, then ret at prog_ctr=20.
- Response: prog_ctr=4 after the ret.
- Also: five nested calls give stack_err=1 on the fifth, and the fifth call still jumps.
REQ-025 Underflow, stall, reset:
- Underflow: ret on empty stack at prog_ctr=9 gives prog_ctr=10 and stack_err=1.
- Stall: stall=1 for 3 cycles with jump_en=1 holds prog_ctr.
- Reset: reset low mid-run clears all outputs immediately, without waiting for a clk edge.

Source files
------------

// File: rtl/pc_seq_pkg.sv
// pc_seq_pkg: shared types for the program-counter sequencer
// Holds the FSM state enum, the branch-condition select codes and the next-PC source enum.
package pc_seq_pkg;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  typedef enum logic [2:0] {RET, CALL, JUMP, BRANCH, SEQ} src_t;
  localparam logic [1:0] FS_ZERO  = 2'b00;
  localparam logic [1:0] FS_NZERO = 2'b01;
  localparam logic [1:0] FS_PARI  = 2'b10;
  localparam logic [1:0] FS_SC    = 2'b11;
endpackage

// File: rtl/pc_sequencer_ret_stack.sv
// ret_stack: LIFO of return addresses, SD entries of D bits
// Ports: clk, reset (async active-low), clr (sync empty), push/din, pop, top (newest entry), full, empty.
module ret_stack #(
  parameter int SD = 4,
  parameter int D = 12
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clr,
  input  logic         push,
  input  logic         pop,
  input  logic [D-1:0] din,
  output logic [D-1:0] top,
  output logic         full,
  output logic         empty
);
  localparam int CW = $clog2(SD + 1);
  logic [CW-1:0] cnt;
  logic [D-1:0] mem [2**CW];
  assign full = cnt == CW'(SD);
  assign empty = cnt == '0;
  assign top = mem[cnt - 1'b1];
  always_ff @(posedge clk or negedge reset)
    if (!reset) cnt <= '0;
    else cnt <= clr ? '0 : (push && !full) ? cnt + 1'b1 : (pop && !empty) ? cnt - 1'b1 : cnt;
  always_ff @(posedge clk)
    if (push && !full) mem[cnt] <= din;
endmodule

// File: rtl/pc_sequencer.sv
// pc_sequencer: program-counter sequencer with target table, return stack and IDLE/RUN/DONE FSM
// Ports: clk, reset (async active-low); req, stall; jump_en/branch_en/call_en/ret_en strobes;
// flag_sel with zero/pari/sc flags; lut_idx (table read); lut_we/lut_wr_idx/lut_wr_addr (table write);
// prog_ctr, fetch_valid, busy, done, stack_err (sticky).
module pc_sequencer
  import pc_seq_pkg::*;
#(
  parameter int D = 12,
  parameter int LW = 6,
  parameter int SD = 4,
  parameter logic [D-1:0] DONE_ADDR = D'(128)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          req,
  input  logic          stall,
  input  logic          jump_en,
  input  logic          branch_en,
  input  logic          call_en,
  input  logic          ret_en,
  input  logic [1:0]    flag_sel,
  input  logic          zero,
  input  logic          pari,
  input  logic          sc,
  input  logic [LW-1:0] lut_idx,
  input  logic          lut_we,
  input  logic [LW-1:0] lut_wr_idx,
  input  logic [D-1:0]  lut_wr_addr,
  output logic [D-1:0]  prog_ctr,
  output logic          fetch_valid,
  output logic          busy,
  output logic          done,
  output logic          stack_err
);
  state_t state;
  src_t src;
  logic [D-1:0] lut [2**LW];
  logic [D-1:0] pc1, target, next_pc, top;
  logic flag, step, full, empty, push, pop, err, clr;
  always_comb begin
    flag = 1'b0;
    case (flag_sel)
      FS_ZERO:  flag = zero;
      FS_NZERO: flag = !zero;
      FS_PARI:  flag = pari;
      FS_SC:    flag = sc;
    endcase
  end
  assign src = ret_en ? RET : call_en ? CALL : jump_en ? JUMP : (branch_en && flag) ? BRANCH : SEQ;
  assign step = busy && !stall && prog_ctr != DONE_ADDR;
  assign fetch_valid = step;
  assign pc1 = prog_ctr + 1'b1;
  assign target = lut[lut_idx];
  // an empty-stack return falls through to the next sequential address
  assign next_pc = src == RET ? (empty ? pc1 : top) : src == SEQ ? pc1 : target;
  assign push = step && src == CALL && !full;
  assign pop = step && src == RET && !empty;
  assign err = step && ((src == CALL && full) || (src == RET && empty));
  assign clr = done && !req;
  ret_stack #(.SD(SD), .D(D)) u_stack (
    .clk(clk), .reset(reset), .clr(clr), .push(push), .pop(pop),
    .din(pc1), .top(top), .full(full), .empty(empty)
  );
  // table writes are accepted in every state; reads see the pre-write value
  always_ff @(posedge clk or negedge reset)
    if (!reset) lut <= '{default: '0};
    else if (lut_we) lut[lut_wr_idx] <= lut_wr_addr;
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state <= IDLE;
      busy <= 1'b0;
      done <= 1'b0;
      prog_ctr <= '0;
      stack_err <= 1'b0;
    end else begin
      unique case (state)
        IDLE: if (req) begin
          state <= RUN;
          busy <= 1'b1;
          stack_err <= 1'b0;
        end
        RUN: if (prog_ctr == DONE_ADDR) begin
          state <= DONE;
          busy <= 1'b0;
          done <= 1'b1;
        end else if (step) begin
          prog_ctr <= next_pc;
          if (err) stack_err <= 1'b1;
        end
        DONE: if (!req) begin
          state <= IDLE;
          done <= 1'b0;
          prog_ctr <= '0;
        end
        default: state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_pc_sequencer.sv
// tb_pc_sequencer: randomized scoreboard bench for pc_sequencer against a queue-based reference model
module tb_pc_sequencer;
  logic clk = 1'b0, reset = 1'b0, req = 1'b0, stall = 1'b0;
  logic jump_en = 1'b0, branch_en = 1'b0, call_en = 1'b0, ret_en = 1'b0;
  logic zero = 1'b0, pari = 1'b0, sc = 1'b0, lut_we = 1'b0;
  logic [1:0] flag_sel = 2'b00;
  logic [5:0] lut_idx = '0, lut_wr_idx = '0;
  logic [11:0] lut_wr_addr = '0;
  logic [11:0] prog_ctr;
  logic fetch_valid, busy, done, stack_err;
  int checks = 0, failures = 0, done_seen = 0, err_seen = 0;

  typedef struct {
    logic [11:0] pc;
    logic busy, done, err, fv;
  } exp_t;
  exp_t q[$];

  // reference model: mode 0 idle, 1 running, 2 finished
  int mst = 0;
  logic [11:0] mpc = '0;
  logic [11:0] stk[$];
  logic merr = 1'b0;
  logic [11:0] mlut[64];

  always #5 clk = ~clk;

  pc_sequencer dut (
    .clk(clk), .reset(reset), .req(req), .stall(stall),
    .jump_en(jump_en), .branch_en(branch_en), .call_en(call_en), .ret_en(ret_en),
    .flag_sel(flag_sel), .zero(zero), .pari(pari), .sc(sc),
    .lut_idx(lut_idx), .lut_we(lut_we), .lut_wr_idx(lut_wr_idx), .lut_wr_addr(lut_wr_addr),
    .prog_ctr(prog_ctr), .fetch_valid(fetch_valid), .busy(busy), .done(done), .stack_err(stack_err)
  );

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", n, act, exp, $time);
    end
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_prog_ctr"}, prog_ctr, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_fetch_valid"}, fetch_valid, 0);
    chk({tag, "_stack_err"}, stack_err, 0);
  endtask

  task automatic model_reset();
    mst = 0;
    mpc = '0;
    merr = 1'b0;
    stk.delete();
    foreach (mlut[k]) mlut[k] = '0;
  endtask

  // monitor: fetch_valid sampled mid-low-phase, registered outputs after the edge
  initial begin
    logic fv;
    exp_t e;
    forever begin
      @(negedge clk);
      #2 fv = fetch_valid;
      @(posedge clk);
      #1;
      if (q.size() != 0) begin
        e = q.pop_front();
        chk("fetch_valid", fv, e.fv);
        chk("prog_ctr", prog_ctr, e.pc);
        chk("busy", busy, e.busy);
        chk("done", done, e.done);
        chk("stack_err", stack_err, e.err);
        if (done) done_seen++;
        if (stack_err) err_seen++;
      end
    end
  end

  initial begin
    exp_t e;
    logic [11:0] tgt;
    logic f;
    int pick;
    model_reset();
    #1 chk_reset("init");
    for (int i = 0; i < 4000; i++) begin
      @(negedge clk);
      if (i % 800 == 400) begin
        #3 reset = 1'b0;
        #1 chk_reset("async_reset");
        model_reset();
      end else begin
        reset = 1'b1;
        req = (mst == 2) ? ($urandom_range(3) == 0) : ($urandom_range(3) != 0);
        stall = ($urandom_range(4) == 0);
        ret_en = ($urandom_range(7) == 0);
        call_en = ($urandom_range(5) == 0);
        jump_en = ($urandom_range(7) == 0);
        branch_en = ($urandom_range(3) == 0);
        flag_sel = 2'($urandom_range(3));
        zero = 1'($urandom_range(1));
        pari = 1'($urandom_range(1));
        sc = 1'($urandom_range(1));
        lut_idx = 6'($urandom_range(3));
        lut_we = ($urandom_range(3) == 0);
        lut_wr_idx = ($urandom_range(1) == 1) ? lut_idx : 6'($urandom_range(3));
        pick = $urandom_range(3);
        lut_wr_addr = pick == 0 ? 12'd128 : pick == 1 ? 12'd4095 : pick == 2 ? 12'd127 : 12'($urandom_range(200));
        e.fv = mst == 1 && !stall && mpc != 12'd128;
        f = flag_sel == 2'b00 ? zero : flag_sel == 2'b01 ? !zero : flag_sel == 2'b10 ? pari : sc;
        case (mst)
          0: if (req) begin
            mst = 1;
            merr = 1'b0;
          end
          1: if (mpc == 12'd128) mst = 2;
          else if (!stall) begin
            tgt = mlut[lut_idx];
            if (ret_en) begin
              if (stk.size() == 0) begin
                merr = 1'b1;
                mpc = 12'(mpc + 1);
              end else mpc = stk.pop_back();
            end else if (call_en) begin
              if (stk.size() == 4) merr = 1'b1;
              else stk.push_back(12'(mpc + 1));
              mpc = tgt;
            end else if (jump_en || (branch_en && f)) mpc = tgt;
            else mpc = 12'(mpc + 1);
          end
          default: if (!req) begin
            mst = 0;
            mpc = '0;
            stk.delete();
          end
        endcase
        if (lut_we) mlut[lut_wr_idx] = lut_wr_addr;
        e.pc = mpc;
        e.busy = mst == 1;
        e.done = mst == 2;
        e.err = merr;
        q.push_back(e);
      end
    end
    repeat (2) @(posedge clk);
    #2;
    chk("queue_drained", q.size(), 0);
    chk("done_reached", done_seen > 0, 1);
    chk("stack_err_reached", err_seen > 0, 1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
